// File: rtl/ailn_moment_unit.sv
// Streaming first/second moment engine: sums x and x^2 over N samples, then divides both by N
// with two bit-serial restoring dividers. Define AILN_MOMENT_VAR_EN to add the registered variance stage.
module ailn_moment_unit #(
  parameter int N      = 8,
  parameter int DATA_W = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_x,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_ex,
  output logic [2*DATA_W-2:0]      o_ex2,
  output logic [2*DATA_W-2:0]      o_var
);
  localparam int CNT_W  = $clog2(N);
  localparam int DIV_W  = $clog2(N+1);
  localparam int SQ_W   = 2*DATA_W-1;
  localparam int ACC1_W = DATA_W+CNT_W;
  localparam int ACC2_W = SQ_W+CNT_W;
  localparam int DC_W   = $clog2(ACC2_W+1);
  localparam logic [DIV_W:0] NDIV = (DIV_W+1)'(N);

  typedef enum logic [1:0] {S_ACC, S_DIV, S_VAR, S_OUT} state_t;
  state_t state;

  logic [CNT_W-1:0]         cnt;
  logic signed [ACC1_W-1:0] acc1, acc1_nx;
  logic [ACC2_W-1:0]        acc2, acc2_nx;
  logic signed [2*DATA_W-1:0] sq_full;
  logic [ACC1_W-1:0]        abs1;
  logic [ACC2_W-1:0]        q1, q2;
  logic [DIV_W-1:0]         rem1, rem2, r1_sub, r2_sub;
  logic [DIV_W:0]           r1_sh, r2_sh;
  logic                     ge1, ge2, neg;
  logic [DC_W-1:0]          dcnt;

  assign o_ready = (state == S_ACC);

  // x*x is non-negative, so zero-extending the full product is exact
  assign sq_full = i_x * i_x;
  assign acc1_nx = acc1 + ACC1_W'(i_x);
  assign acc2_nx = acc2 + ACC2_W'($unsigned(sq_full));
  assign abs1    = acc1_nx[ACC1_W-1] ? $unsigned(-acc1_nx) : $unsigned(acc1_nx);

  // One restoring step per cycle: shift in the next dividend bit, subtract N if it fits
  assign r1_sh  = {rem1, q1[ACC2_W-1]};
  assign r2_sh  = {rem2, q2[ACC2_W-1]};
  assign ge1    = (r1_sh >= NDIV);
  assign ge2    = (r2_sh >= NDIV);
  assign r1_sub = DIV_W'(r1_sh - NDIV);
  assign r2_sub = DIV_W'(r2_sh - NDIV);

`ifdef AILN_MOMENT_VAR_EN
  logic signed [2*DATA_W-1:0] ex_sq;
  assign ex_sq = o_ex * o_ex;
`else
  assign o_var = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_ACC;
      cnt     <= '0;
      acc1    <= '0;
      acc2    <= '0;
      q1      <= '0;
      q2      <= '0;
      rem1    <= '0;
      rem2    <= '0;
      neg     <= 1'b0;
      dcnt    <= '0;
      o_valid <= 1'b0;
      o_ex    <= '0;
      o_ex2   <= '0;
`ifdef AILN_MOMENT_VAR_EN
      o_var   <= '0;
`endif
    end else if (i_flush) begin
      state   <= S_ACC;
      cnt     <= '0;
      acc1    <= '0;
      acc2    <= '0;
      dcnt    <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        S_ACC: if (i_valid) begin
          acc1 <= acc1_nx;
          acc2 <= acc2_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(N-1)) begin
            cnt   <= '0;
            q1    <= ACC2_W'(abs1);
            q2    <= acc2_nx;
            rem1  <= '0;
            rem2  <= '0;
            neg   <= acc1_nx[ACC1_W-1];
            dcnt  <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: if (dcnt == DC_W'(ACC2_W)) begin
          o_ex  <= neg ? DATA_W'(-q1[DATA_W-1:0]) : q1[DATA_W-1:0];
          o_ex2 <= q2[SQ_W-1:0];
`ifdef AILN_MOMENT_VAR_EN
          state <= S_VAR;
`else
          o_valid <= 1'b1;
          state   <= S_OUT;
`endif
        end else begin
          rem1 <= ge1 ? r1_sub : r1_sh[DIV_W-1:0];
          rem2 <= ge2 ? r2_sub : r2_sh[DIV_W-1:0];
          q1   <= {q1[ACC2_W-2:0], ge1};
          q2   <= {q2[ACC2_W-2:0], ge2};
          dcnt <= dcnt + 1'b1;
        end
`ifdef AILN_MOMENT_VAR_EN
        S_VAR: begin
          o_var   <= o_ex2 - SQ_W'($unsigned(ex_sq));
          o_valid <= 1'b1;
          state   <= S_OUT;
        end
`endif
        S_OUT: if (i_ready) begin
          o_valid <= 1'b0;
          cnt     <= '0;
          acc1    <= '0;
          acc2    <= '0;
          state   <= S_ACC;
        end
        default: state <= S_ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_ailn_moment_unit.sv
// Scoreboard bench: N=8 and N=5 instances; expected moments computed from the driven samples.
module tb_ailn_moment_unit;
  localparam int ACC2_W8 = 17 + 3;
  localparam int ACC2_W5 = 17 + 3;
`ifdef AILN_MOMENT_VAR_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif

  typedef struct { int d; int ex; int ex2; int vr; } exp_t;
  exp_t sb[$];

  logic clk = 1'b0, rst = 1'b1;
  logic flush[2], valid[2], ready[2], ovalid[2], iready[2];
  logic signed [8:0] x[2], ex[2];
  logic [16:0] ex2[2], vr[2];
  int cyc = 0, last_acc[2], lat[2];
  int total = 0, pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ailn_moment_unit #(.N(8), .DATA_W(9)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[0]), .i_valid(valid[0]), .o_ready(ready[0]),
    .i_x(x[0]), .o_valid(ovalid[0]), .i_ready(iready[0]), .o_ex(ex[0]), .o_ex2(ex2[0]), .o_var(vr[0]));
  ailn_moment_unit #(.N(5), .DATA_W(9)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[1]), .i_valid(valid[1]), .o_ready(ready[1]),
    .i_x(x[1]), .o_valid(ovalid[1]), .i_ready(iready[1]), .o_ex(ex[1]), .o_ex2(ex2[1]), .o_var(vr[1]));

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got == exp) pass++;
    else $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_exp(int d, int xs[$]);
    exp_t e;
    int s = 0, s2 = 0;
    foreach (xs[i]) begin s += xs[i]; s2 += xs[i] * xs[i]; end
    e.d   = d;
    e.ex  = s / xs.size();
    e.ex2 = s2 / xs.size();
    e.vr  = VX ? e.ex2 - e.ex * e.ex : 0;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic feed(int d, int v);
    int n = 0;
    valid[d] = 1'b1;
    x[d] = 9'(v);
    while (!ready[d] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("feed_timeout", 0, 1);
    @(negedge clk);
    last_acc[d] = cyc;
    valid[d] = 1'b0;
  endtask

  task automatic get_result(int d, int hold);
    exp_t e;
    int n = 0, rdy_seen = 0;
    iready[d] = (hold == 0);
    while (!ovalid[d] && n < 200) begin @(negedge clk); n++; end
    chk("latency", cyc - last_acc[d], lat[d] + VX);
    if (hold > 0) begin
      valid[d] = 1'b1;
      x[d] = 9'sd99;
      repeat (hold) begin @(negedge clk); rdy_seen |= int'(ready[d]); end
      chk("bp_valid", int'(ovalid[d]), 1);
      chk("bp_ready", rdy_seen, 0);
      valid[d] = 1'b0;
      iready[d] = 1'b1;
    end
    if (sb.size() == 0) begin chk("sb_empty", 0, 1); return; end
    e = sb.pop_front();
    chk("dut_id", d, e.d);
    chk("o_ex", int'(ex[d]), e.ex);
    chk("o_ex2", int'(ex2[d]), e.ex2);
    chk("o_var", int'(vr[d]), e.vr);
    @(negedge clk);
    chk("post_valid", int'(ovalid[d]), 0);
    chk("post_ready", int'(ready[d]), 1);
    chk("keep_ex", int'(ex[d]), e.ex);
  endtask

  task automatic run_group(int d, int xs[$], int gaps, int hold);
    push_exp(d, xs);
    foreach (xs[i]) begin
      feed(d, xs[i]);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    get_result(d, hold);
  endtask

  initial begin
    int xs[$];
    int seen;
    lat[0] = ACC2_W8 + 1;
    lat[1] = ACC2_W5 + 1;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; valid[d] = 1'b0; iready[d] = 1'b1; x[d] = '0; last_acc[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", int'(ovalid[0]), 0);
    chk("rst_ready", int'(ready[0]), 1);
    chk("rst_ex", int'(ex[0]), 0);
    chk("rst_ex2", int'(ex2[0]), 0);
    chk("rst_var", int'(vr[0]), 0);

    xs = {3, 3, 3, 3, 3, 3, 3, 3};                 run_group(0, xs, 0, 0);
    xs = {1, 2, 3, 4, 5, 6, 7, 8};                 run_group(0, xs, 0, 10);
    xs = {-1, -2, -3, -4, -5, -6, -7, -8};         run_group(0, xs, 1, 0);
    xs = {-256, -256, -256, -256, -256, -256, -256, -256}; run_group(0, xs, 0, 0);
    xs = {255, 255, 255, 255, 255, 255, 255, 254}; run_group(0, xs, 0, 0);
    xs = {1, 2, 3, 4, 5};                          run_group(1, xs, 1, 0);
    xs = {-7, 100, -256, 3, 9};                    run_group(1, xs, 1, 3);
    for (int g = 0; g < 3; g++) begin
      xs = {};
      for (int i = 0; i < 8; i++) xs.push_back($urandom_range(0, 511) - 256);
      run_group(0, xs, 1, 0);
    end

    // Flush after 4 samples; a sample offered in the flush cycle must be dropped
    for (int i = 0; i < 4; i++) feed(0, 7);
    flush[0] = 1'b1; valid[0] = 1'b1; x[0] = 9'sd50;
    @(negedge clk);
    flush[0] = 1'b0; valid[0] = 1'b0;
    chk("flush_ready", int'(ready[0]), 1);
    chk("flush_valid", int'(ovalid[0]), 0);
    xs = {2, 2, 2, 2, 2, 2, 2, 2};                 run_group(0, xs, 0, 0);

    // Reset during the divide: group discarded, outputs cleared
    for (int i = 0; i < 8; i++) feed(0, 5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= int'(ovalid[0]); end
    chk("middiv_no_valid", seen, 0);
    chk("middiv_ex", int'(ex[0]), 0);
    chk("middiv_ex2", int'(ex2[0]), 0);
    chk("middiv_ready", int'(ready[0]), 1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
